// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle chunked add/subtract unit with C/V/Z/N flags
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, least
// significant chunk first, and reuses one CHUNK-bit adder for every chunk.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous active-high reset; aborts an operation in progress
//   start  - request a new operation, sampled only while busy is low
//   sub    - 0 = add (a+b+cin), 1 = subtract (a-b-cin); latched at acceptance
//   a, b   - operands, latched at acceptance
//   cin    - carry-in for add, borrow-in for subtract; latched at acceptance
//   busy   - high while an operation is in progress
//   done   - one-cycle pulse when sum and flags are updated
//   sum    - result modulo 2^WIDTH, held between completions
//   C      - raw carry out of the MSB (for subtract, 1 means no borrow)
//   V      - two's-complement signed overflow
//   Z      - sum is zero
//   N      - sum MSB
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             C,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int NCH = WIDTH / CHUNK;
    // Keep the counter at least one bit wide so CHUNK == WIDTH still elaborates.
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] beff_r;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] r_ch;
    logic             cout;
    logic             last;

    // One narrow adder; the operand chunk is selected by the counter.
    always_comb begin
        a_ch = a_r[int'(cnt)*CHUNK +: CHUNK];
        b_ch = beff_r[int'(cnt)*CHUNK +: CHUNK];
        {cout, r_ch} = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
        // Full result as it stands after this chunk, so the completion edge can
        // publish sum and flags together without waiting another cycle.
        sum_nxt = shadow;
        sum_nxt[int'(cnt)*CHUNK +: CHUNK] = r_ch;
        last = (cnt == CW'(NCH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state == RUN);
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            beff_r <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            done   <= 1'b0;
            sum    <= '0;
            C      <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
            N      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + ~cin, so cin acts as a borrow.
                        a_r    <= a;
                        beff_r <= sub ? ~b : b;
                        carry  <= sub ? ~cin : cin;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    shadow <= sum_nxt;
                    carry  <= cout;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        cnt  <= '0;
                        done <= 1'b1;
                        sum  <= sum_nxt;
                        C    <= cout;
                        V    <= (a_r[WIDTH-1] == beff_r[WIDTH-1]) &&
                                (sum_nxt[WIDTH-1] != a_r[WIDTH-1]);
                        Z    <= ~|sum_nxt;
                        N    <= sum_nxt[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - self-checking bench for chunked_adder (16/4 and 8/8)
module tb_chunked_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start16, sub16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, c16, v16, z16, n16;
    logic [15:0] sum16;

    logic        start8, sub8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, c8, v8, z8, n8;
    logic [7:0]  sum8;

    chunked_adder #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .sum(sum16),
        .C(c16), .V(v16), .Z(z16), .N(n16)
    );

    chunked_adder #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8),
        .C(c8), .V(v8), .Z(z8), .N(n8)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        longint s;
        bit     c, v, z, n;
    } res_t;

    typedef struct {
        bit          w8;
        bit          sb;
        logic [15:0] a, b;
        bit          ci;
        logic [15:0] s;
        bit          c, v, z, n;
    } vec_t;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic res_t model(input int w, input bit sb, input longint a,
                                   input longint b, input bit ci);
        res_t   r;
        longint m    = (longint'(1) << w);
        longint sa   = (a >= m / 2) ? a - m : a;
        longint sbv  = (b >= m / 2) ? b - m : b;
        longint full;
        longint rs;
        if (!sb) begin
            full = a + b + longint'(ci);
            r.c  = (full >= m);
            rs   = sa + sbv + longint'(ci);
        end else begin
            full = a - b - longint'(ci);
            r.c  = (full >= 0);
            rs   = sa - sbv - longint'(ci);
        end
        r.s = full & (m - 1);
        r.v = (rs < -(m / 2)) || (rs > (m / 2) - 1);
        r.z = (r.s == 0);
        r.n = ((r.s >> (w - 1)) & 1) != 0;
        return r;
    endfunction

    task automatic check_out16(input string tag, input res_t e);
        chk({tag, " sum"}, sum16, e.s);
        chk({tag, " C"}, c16, e.c);
        chk({tag, " V"}, v16, e.v);
        chk({tag, " Z"}, z16, e.z);
        chk({tag, " N"}, n16, e.n);
    endtask

    // Issue one op on the 16-bit unit; optionally pulse start at count 'poke'.
    task automatic run16(input bit sb, input logic [15:0] a, input logic [15:0] b,
                         input bit ci, input res_t e, input int poke, input string tag);
        int n;
        @(negedge clk);
        start16 = 1'b1; sub16 = sb; a16 = a; b16 = b; cin16 = ci;
        n = 1;
        @(negedge clk);
        chk({tag, " busy"}, busy16, 1);
        while (!done16 && n < 40) begin
            start16 = (n == poke);
            sub16   = ~sb;
            a16     = 16'($urandom);
            b16     = 16'($urandom);
            @(negedge clk);
            n++;
        end
        start16 = 1'b0;
        chk({tag, " latency"}, n, 5);
        check_out16(tag, e);
        @(negedge clk);
        chk({tag, " done pulse"}, done16, 0);
        chk({tag, " sum held"}, sum16, e.s);
    endtask

    task automatic run8(input bit sb, input logic [7:0] a, input logic [7:0] b,
                        input bit ci, input res_t e, input string tag);
        int n;
        @(negedge clk);
        start8 = 1'b1; sub8 = sb; a8 = a; b8 = b; cin8 = ci;
        n = 1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, n, 2);
        chk({tag, " sum"}, sum8, e.s);
        chk({tag, " C"}, c8, e.c);
        chk({tag, " V"}, v8, e.v);
        chk({tag, " Z"}, z8, e.z);
        chk({tag, " N"}, n8, e.n);
    endtask

    vec_t vt[9];

    initial begin
        res_t e;
        int   m;
        int   dones;

        vt[0] = '{0, 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1, 0, 1};
        vt[1] = '{0, 0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1, 0, 1, 0};
        vt[2] = '{0, 0, 16'd200,  16'd100,  1, 16'd301,  0, 0, 0, 0};
        vt[3] = '{0, 1, 16'd5,    16'd7,    0, 16'hFFFE, 0, 0, 0, 1};
        vt[4] = '{0, 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1, 0, 0};
        vt[5] = '{0, 1, 16'h0000, 16'h0000, 1, 16'hFFFF, 0, 0, 0, 1};
        vt[6] = '{0, 1, 16'd5,    16'd5,    0, 16'h0000, 1, 0, 1, 0};
        vt[7] = '{1, 0, 16'd200,  16'd100,  1, 16'd45,   1, 0, 0, 0};
        vt[8] = '{1, 0, 16'd0,    16'd0,    0, 16'd0,    0, 0, 1, 0};

        rst = 1'b1;
        start16 = 0; sub16 = 0; cin16 = 0; a16 = 0; b16 = 0;
        start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset busy", busy16, 0);
        chk("reset done", done16, 0);
        check_out16("reset", '{0, 0, 0, 0, 0});
        chk("reset8 sum", sum8, 0);
        chk("reset8 busy", busy8, 0);

        for (int i = 0; i < 9; i++) begin
            e = '{longint'(vt[i].s), vt[i].c, vt[i].v, vt[i].z, vt[i].n};
            if (vt[i].w8)
                run8(vt[i].sb, vt[i].a[7:0], vt[i].b[7:0], vt[i].ci, e, $sformatf("vec%0d", i));
            else
                run16(vt[i].sb, vt[i].a, vt[i].b, vt[i].ci, e, -1, $sformatf("vec%0d", i));
        end

        // start pulsed mid-operation with other operands must be ignored
        run16(0, 16'h1234, 16'h1111, 0, model(16, 0, 16'h1234, 16'h1111, 0), 2, "ignore");

        // back-to-back: start held through the done cycle
        @(negedge clk);
        start16 = 1; sub16 = 0; a16 = 16'd1; b16 = 16'd2; cin16 = 0;
        m = 1;
        @(negedge clk);
        a16 = 16'hAAAA; b16 = 16'h5555;
        while (!done16 && m < 40) begin @(negedge clk); m++; end
        chk("b2b first latency", m, 5);
        chk("b2b first sum", sum16, 3);
        sub16 = 1; a16 = 16'd10; b16 = 16'd3; cin16 = 0;
        m = 0;
        @(negedge clk);
        m++;
        start16 = 0;
        chk("b2b accepted busy", busy16, 1);
        while (!done16 && m < 40) begin @(negedge clk); m++; end
        chk("b2b second spacing", m, 5);
        check_out16("b2b second", model(16, 1, 10, 3, 0));

        // reset mid-RUN aborts with no done pulse
        @(negedge clk);
        start16 = 1; sub16 = 0; a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1;
        repeat (3) @(negedge clk);
        start16 = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort busy", busy16, 0);
        chk("abort done", done16, 0);
        check_out16("abort", '{0, 0, 0, 0, 0});
        dones = 0;
        repeat (8) begin @(negedge clk); if (done16) dones++; end
        chk("abort no done", dones, 0);
        run16(0, 16'hFFFF, 16'hFFFF, 1, model(16, 0, 16'hFFFF, 16'hFFFF, 1), -1, "after abort");

        // randomized against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra, rb;
            bit          rs, rc;
            ra = 16'($urandom); rb = 16'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            if (i % 5 == 0) rb = ra;
            run16(rs, ra, rb, rc, model(16, rs, ra, rb, rc), -1, $sformatf("rnd16_%0d", i));
        end
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            bit         rs, rc;
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            run8(rs, ra, rb, rc, model(8, rs, ra, rb, rc), $sformatf("rnd8_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Parametrised multi-cycle add/subtract unit with carry-in and full flag set (C, V, Z, N).
- Processes operands CHUNK bits per clock, LSB chunk first, so wide datapaths reuse one narrow adder.
- Used as the shared arithmetic engine behind ALU and accumulator blocks.
- Start/busy/done handshake; results are registered and held until the next completion.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; CHUNK == WIDTH gives a single-cycle operation.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when busy=0.
- sub  input  1  0 = add, 1 = subtract; latched at acceptance.
- a  input  WIDTH  operand A; latched at acceptance.
- b  input  WIDTH  operand B; latched at acceptance.
- cin  input  1  carry-in (add) or borrow-in (sub); latched at acceptance.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum and flags are updated.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- C  output  1  raw carry out of the MSB.
- V  output  1  two's-complement signed overflow.
- Z  output  1  high when sum == 0.
- N  output  1  equals sum[WIDTH-1].

Behaviour:
- Reset: state IDLE, busy=0, done=0, sum=0, C=0, V=0, Z=0, N=0, chunk counter=0. Reset during RUN aborts the operation; no done pulse is produced.
- Operand preparation at acceptance:
  - beff = sub ? ~b : b
  - carry register = sub ? ~cin : cin
  - Result: add gives a+b+cin; sub gives a-b-cin.
  - C is the raw carry: in subtract, C=1 means no borrow.
- States:
  - IDLE: start=1 moves to RUN at that edge, latches the operands, busy goes to 1, counter=0.
  - RUN: each edge adds chunk[counter] of a, beff and the carry register; stores CHUNK result bits into the sum shadow register; updates the carry register; increments counter.
  - Completion edge (counter == WIDTH/CHUNK-1) does all of the following:
    - writes the final sum, C, V, Z, N to the outputs;
    - sets done=1 for exactly one cycle and busy=0;
    - returns to IDLE.
- Latency: NCH = WIDTH/CHUNK. For start accepted at edge k, done is high in the cycle after edge k+NCH.
- Back-to-back: start seen during the done cycle (state IDLE) is accepted, giving one operation per NCH+1 cycles.
- start while busy=1 is ignored. The operand inputs may change freely while busy; they do not affect the operation in progress.
- Sum, C, V, Z, N hold their values between completions and are never partially updated; the chunk shadow register is internal.
- Flags at completion:
  - V = (a[MSB] == beff[MSB]) && (sum[MSB] != a[MSB]), computed on the latched values.
  - Z = ~|sum.
  - N = sum[MSB].
- Wrap-around: sum is always modulo 2^WIDTH; carry out of the top chunk goes only to C.

Test Plan:
- WIDTH=16, CHUNK=4, add, a=0x7FFF, b=0x0001, cin=0 -> done in the 5th cycle after the start edge; sum=0x8000, C=0, V=1, Z=0, N=1.
- Add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, C=1, V=0, Z=1, N=0. Then a=200, b=100, cin=1 -> sum=301, all flags 0.
- Subtract a=5, b=7, cin=0 -> sum=0xFFFE, C=0, V=0, N=1. Subtract a=0x8000, b=1, cin=0 -> sum=0x7FFF, C=1, V=1.
- Pulse start at cycle 2 of a running operation with different operands -> ignored; the original result is produced on time. start held through the done cycle -> the second operation is accepted immediately and its done arrives NCH+1 cycles after the first.
- Assert rst for one cycle mid-RUN -> all outputs 0 on the next cycle; no done pulse; the next start completes normally.
- WIDTH=8, CHUNK=8, a=200, b=100, cin=1 -> one-cycle latency, sum=45, C=1, V=0, Z=0; a=0, b=0, cin=0 -> sum=0, Z=1.
